fifo_stream_out: RTL and testbench

Read-side adapter that sits directly downstream of a synchronous FIFO configured without first-word-fall-through. It pulls words from the FIFO, absorbs the FIFO's one-cycle read latency in a 3-entry skid buffer, and presents them on a valid/ready stream at full throughput. Bit P_DATA_WIDTH-1 of each word is the end-of-frame flag. The enable control stops fetching only at frame boundaries, and the block counts delivered frames.

---
 rtl/fifo_stream_out_if.sv | 12 +
 rtl/fifo_stream_out.sv | 148 ++++++++++++++
 tb/tb_fifo_stream_out.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_out_if.sv
// Valid/ready stream carrying one FIFO word split into payload and end-of-frame.
interface fifo_stream_out_if #(
  parameter int unsigned P_DATA_WIDTH = 33
);
  logic                    valid;
  logic [P_DATA_WIDTH-2:0] data;
  logic                    last;
  logic                    ready;

  modport master (output valid, data, last, input ready);
  modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/fifo_stream_out.sv
// Read-side adapter for a non-FWFT synchronous FIFO: fetches words, absorbs the
// one-cycle read latency in a 3-entry skid buffer and streams them out at full
// rate. Fetch enable is honoured only at frame boundaries; delivered frames are counted.
module fifo_stream_out #(
  parameter int unsigned P_DATA_WIDTH = 33,
  parameter int unsigned P_CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  output logic                    fifo_rd_o,
  input  logic [P_DATA_WIDTH-1:0] fifo_data_i,
  input  logic                    fifo_empty_i,
  fifo_stream_out_if.master       m_if,
  output logic [P_CNT_WIDTH-1:0]  frame_cnt_o,
  output logic                    idle_o
);

  localparam int unsigned LP_DEPTH = 3;
  localparam int unsigned LP_PTR_W = 2;
  localparam int unsigned LP_OCC_W = 3;
  localparam int unsigned LP_MSB   = P_DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  state_e                  state_q;
  logic [P_DATA_WIDTH-1:0] buf_q [LP_DEPTH];
  logic [LP_PTR_W-1:0]     head_q, head_d;
  logic [LP_PTR_W-1:0]     tail_q, tail_d;
  logic [LP_PTR_W-1:0]     count_q, count_d;
  logic                    inflight_q;
  logic                    in_frame_q, in_frame_d;
  logic [P_CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;

  logic                    land;
  logic                    land_last;
  logic                    pop;
  logic                    valid;
  logic                    frame_open;
  logic [P_DATA_WIDTH-1:0] head_word;

  function automatic logic [LP_PTR_W-1:0] ptr_inc(input logic [LP_PTR_W-1:0] p);
    return (p == LP_PTR_W'(LP_DEPTH - 1)) ? '0 : p + LP_PTR_W'(1);
  endfunction

  // Handshake, issue and status decode from registered state
  always_comb begin
    land       = inflight_q;
    land_last  = fifo_data_i[LP_MSB];
    valid      = (count_q != '0);
    pop        = valid & m_if.ready;
    head_word  = buf_q[head_q];
    frame_open = in_frame_q | (land & ~land_last);
    // Occupancy counts reads already in flight, so ready never reaches the strobe
    fifo_rd_o  = (state_q != ST_IDLE) & ~fifo_empty_i &
                 ((LP_OCC_W'(count_q) + LP_OCC_W'(inflight_q)) < LP_OCC_W'(LP_DEPTH));
    idle_o     = (state_q == ST_IDLE) & (count_q == '0) & ~inflight_q;
  end

  assign m_if.valid  = valid;
  assign m_if.data   = head_word[P_DATA_WIDTH-2:0];
  assign m_if.last   = head_word[LP_MSB];
  assign frame_cnt_o = frame_cnt_q;

  // Next-state for buffer pointers, occupancy, frame tracking and frame counter
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    in_frame_d  = in_frame_q;
    frame_cnt_d = frame_cnt_q;
    if (land) begin
      tail_d     = ptr_inc(tail_q);
      in_frame_d = ~land_last;
    end
    if (pop) begin
      head_d = ptr_inc(head_q);
      if (head_word[LP_MSB]) begin
        frame_cnt_d = frame_cnt_q + P_CNT_WIDTH'(1);
      end
    end
    case ({land, pop})
      2'b10:   count_d = count_q + LP_PTR_W'(1);
      2'b01:   count_d = count_q - LP_PTR_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      in_frame_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      inflight_q  <= fifo_rd_o;
      in_frame_q  <= in_frame_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Skid buffer storage; cleared on reset so the head word reads as zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(LP_DEPTH); i++) begin
        buf_q[i] <= '0;
      end
    end else if (land) begin
      buf_q[tail_q] <= fifo_data_i;
    end
  end

  // Fetch-control FSM: stopping waits for the open frame's last word to land
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable_i) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!enable_i) state_q <= frame_open ? ST_STOPPING : ST_IDLE;
        end
        ST_STOPPING: begin
          if (enable_i)               state_q <= ST_RUN;
          else if (land && land_last) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A landing word must always find a free slot
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(land && !pop && (count_q == LP_PTR_W'(LP_DEPTH))));

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed bench: non-FWFT FIFO model feeding the adapter, in-order delivery
// checked against the push history, frame counter checked against hand values.
module tb_fifo_stream_out;

  localparam int unsigned DW = 9;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_rd;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic [CW-1:0] frame_cnt;
  logic          idle;

  always #5 clk = ~clk;

  fifo_stream_out_if #(.P_DATA_WIDTH(DW)) m_if ();

  fifo_stream_out #(.P_DATA_WIDTH(DW), .P_CNT_WIDTH(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .fifo_rd_o    (fifo_rd),
    .fifo_data_i  (fifo_data),
    .fifo_empty_i (fifo_empty),
    .m_if         (m_if),
    .frame_cnt_o  (frame_cnt),
    .idle_o       (idle)
  );

  // FIFO model: words pushed by the stimulus, read data registered one cycle after the strobe
  logic [DW-1:0] mem [128];
  int push_cnt = 0;
  int pop_cnt  = 0;

  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_cnt   <= push_cnt;
      fifo_data <= '0;
    end else if (fifo_rd) begin
      fifo_data <= mem[7'(pop_cnt)];
      pop_cnt   <= pop_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int dcnt   = 0;
  logic          hold = 1'b0;
  logic [DW-1:0] held = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic last);
    mem[7'(push_cnt)] = {last, 8'(push_cnt + 16)};
    push_cnt++;
  endtask

  // One clock: check stability under stall and any pop about to happen, then advance
  task automatic tick();
    if (hold) begin
      chk("stall_valid", 32'(m_if.valid), 32'd1);
      chk("stall_data", 32'({m_if.last, m_if.data}), 32'(held));
    end
    if (m_if.valid && m_if.ready) begin
      chk("pop_data", 32'({m_if.last, m_if.data}), 32'(mem[7'(dcnt)]));
      dcnt++;
    end
    hold = m_if.valid && !m_if.ready;
    held = {m_if.last, m_if.data};
    @(posedge clk);
    @(negedge clk);
  endtask

  int vcnt;
  int rises;
  int gaps;
  logic vprev;

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    m_if.ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_rd", 32'(fifo_rd), 32'd0);
    chk("rst_valid", 32'(m_if.valid), 32'd0);
    chk("rst_data", 32'(m_if.data), 32'd0);
    chk("rst_last", 32'(m_if.last), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    rst = 1'b0;
    tick();

    // Enabled with empty FIFO: no read, nothing valid, no longer idle
    enable     = 1'b1;
    m_if.ready = 1'b1;
    tick();
    chk("empty_rd", 32'(fifo_rd), 32'd0);
    chk("empty_valid", 32'(m_if.valid), 32'd0);
    chk("empty_idle", 32'(idle), 32'd0);

    // Single word: strobe in the push cycle, data from FIFO next cycle, valid after it lands
    push(1'b1);
    #1;
    chk("single_rd", 32'(fifo_rd), 32'd1);
    tick();
    tick();
    chk("single_valid", 32'(m_if.valid), 32'd1);
    chk("single_word", 32'({m_if.last, m_if.data}), 32'h110);
    tick();
    chk("single_fcnt", 32'(frame_cnt), 32'd1);
    chk("single_drained", 32'(m_if.valid), 32'd0);

    // Streaming: 8-word frame must come out as one unbroken valid burst
    for (int i = 0; i < 8; i++) push(i == 7);
    vcnt  = 0;
    rises = 0;
    vprev = 1'b0;
    repeat (16) begin
      if (m_if.valid) vcnt++;
      if (m_if.valid && !vprev) rises++;
      vprev = m_if.valid;
      tick();
    end
    chk("stream_vcnt", 32'(vcnt), 32'd8);
    chk("stream_bursts", 32'(rises), 32'd1);
    chk("stream_fcnt", 32'(frame_cnt), 32'd2);
    chk("stream_dcnt", 32'(dcnt), 32'd9);

    // Backpressure: stall 10 cycles mid-frame, buffer fills and fetching stops
    for (int i = 0; i < 12; i++) push(i == 11);
    repeat (4) tick();
    m_if.ready = 1'b0;
    repeat (10) tick();
    chk("bp_count", 32'(dut.count_q), 32'd3);
    chk("bp_rd", 32'(fifo_rd), 32'd0);
    chk("bp_valid", 32'(m_if.valid), 32'd1);
    m_if.ready = 1'b1;
    repeat (20) tick();
    chk("bp_dcnt", 32'(dcnt), 32'd21);
    chk("bp_fcnt", 32'(frame_cnt), 32'd3);
    chk("bp_valid_end", 32'(m_if.valid), 32'd0);

    // Stop mid-frame: 20-word frame completes, one speculative read past last
    for (int i = 0; i < 20; i++) push(i == 19);
    for (int i = 0; i < 4; i++) push(i == 3);
    repeat (7) tick();
    enable = 1'b0;
    repeat (30) tick();
    chk("stop_popped", 32'(pop_cnt), 32'd42);
    chk("stop_dcnt", 32'(dcnt), 32'd42);
    chk("stop_idle", 32'(idle), 32'd1);
    chk("stop_rd", 32'(fifo_rd), 32'd0);
    chk("stop_fcnt_wrap", 32'(frame_cnt), 32'd0);

    // Stop/restart mid-frame: reads must never pause while the FIFO holds data
    for (int i = 0; i < 10; i++) push(i == 9);
    enable = 1'b1;
    tick();
    gaps = 0;
    for (int i = 1; i < 40; i++) begin
      if (i == 7) enable = 1'b0;
      if (i == 9) enable = 1'b1;
      if (!fifo_empty && !fifo_rd) gaps++;
      tick();
    end
    chk("restart_gaps", 32'(gaps), 32'd0);
    chk("restart_popped", 32'(pop_cnt), 32'd55);
    chk("restart_dcnt", 32'(dcnt), 32'd55);
    chk("restart_fcnt", 32'(frame_cnt), 32'd2);
    chk("restart_idle", 32'(idle), 32'd0);

    // Asynchronous reset mid-frame with a stalled, full buffer
    for (int i = 0; i < 6; i++) push(1'b0);
    m_if.ready = 1'b0;
    repeat (5) tick();
    chk("prerst_valid", 32'(m_if.valid), 32'd1);
    hold = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rd", 32'(fifo_rd), 32'd0);
    chk("arst_valid", 32'(m_if.valid), 32'd0);
    chk("arst_data", 32'(m_if.data), 32'd0);
    chk("arst_last", 32'(m_if.last), 32'd0);
    chk("arst_fcnt", 32'(frame_cnt), 32'd0);
    chk("arst_idle", 32'(idle), 32'd1);
    @(negedge clk);
    rst        = 1'b0;
    dcnt       = push_cnt;
    m_if.ready = 1'b1;

    // Counter wrap: five one-word frames from zero on a 2-bit counter
    for (int i = 0; i < 5; i++) push(1'b1);
    repeat (15) tick();
    chk("wrap_fcnt", 32'(frame_cnt), 32'd1);
    chk("wrap_dcnt", 32'(dcnt), 32'd66);
    chk("wrap_valid", 32'(m_if.valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
